// File: rtl/uart_frame_ctrl_pkg.sv
// Shared definitions for the UART command-frame controller and its baud-tick timeout helper.
package uart_frame_ctrl_pkg;

    localparam int unsigned DefaultDataWidth    = 8;
    localparam int unsigned DefaultTimeoutTicks = 1600;

    typedef enum logic [2:0] {
        StGetA   = 3'd0,
        StGetB   = 3'd1,
        StGetOp  = 3'd2,
        StExec   = 3'd3,
        StSend   = 3'd4,
        StWaitTx = 3'd5
    } state_e;

    // Bits needed to hold 0..max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_timeout.sv
// Saturating baud-tick counter; flags expiry on the tick that reaches TIMEOUT_TICKS.
module baud_timeout
    import uart_frame_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = DefaultTimeoutTicks
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expired
);

    localparam int unsigned     CntW    = cnt_width(TIMEOUT_TICKS);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(TIMEOUT_TICKS);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_TICKS - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational on the final tick so a coincident byte can still take priority.
    assign expired = enable && ((cnt_q == MaxCnt) || (tick && (cnt_q == LastCnt)));

endmodule

// File: rtl/uart_frame_ctrl.sv
// Assembles A/B/opcode frames from UART RX, strobes the ALU and hands the result to UART TX.
module uart_frame_ctrl
    import uart_frame_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
    parameter int unsigned TIMEOUT_TICKS = DefaultTimeoutTicks
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_baud_rate,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [DATA_WIDTH-1:0] o_op,
    output logic                  o_alu_valid,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_busy,
    output logic                  o_drop,
    output logic                  o_timeout
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, op_q, op_d, tx_data_q, tx_data_d;
    logic                  alu_valid_q, tx_start_q, busy_q;
    logic                  drop_q, drop_d, timeout_q, timeout_d;
    logic                  tmo_clear, tmo_enable, tmo_expired;

    assign tmo_enable = (state_q == StGetB) || (state_q == StGetOp);

    baud_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .tick    (i_baud_rate),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
        drop_d    = 1'b0;
        timeout_d = 1'b0;
        tmo_clear = 1'b0;
        unique case (state_q)
            StGetA: begin
                if (i_rx_done) begin
                    a_d       = i_rx_data;
                    tmo_clear = 1'b1;
                    state_d   = StGetB;
                end
            end
            StGetB: begin
                if (i_rx_done) begin
                    b_d       = i_rx_data;
                    tmo_clear = 1'b1;
                    state_d   = StGetOp;
                end else if (tmo_expired) begin
                    timeout_d = 1'b1;
                    tmo_clear = 1'b1;
                    state_d   = StGetA;
                end
            end
            StGetOp: begin
                if (i_rx_done) begin
                    op_d      = i_rx_data;
                    tmo_clear = 1'b1;
                    state_d   = StExec;
                end else if (tmo_expired) begin
                    timeout_d = 1'b1;
                    tmo_clear = 1'b1;
                    state_d   = StGetA;
                end
            end
            StExec: begin
                drop_d    = i_rx_done;
                tx_data_d = i_alu_result;
                state_d   = StSend;
            end
            StSend: begin
                drop_d  = i_rx_done;
                state_d = StWaitTx;
            end
            StWaitTx: begin
                drop_d = i_rx_done;
                if (i_tx_done) begin
                    state_d = StGetA;
                end
            end
            default: begin
                state_d = StGetA;
            end
        endcase
    end

    // Status strobes decode the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StGetA;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            tx_data_q   <= '0;
            alu_valid_q <= 1'b0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            tx_data_q   <= tx_data_d;
            alu_valid_q <= (state_d == StExec);
            tx_start_q  <= (state_d == StSend);
            busy_q      <= (state_d != StGetA);
            drop_q      <= drop_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_a         = a_q;
    assign o_b         = b_q;
    assign o_op        = op_q;
    assign o_tx_data   = tx_data_q;
    assign o_alu_valid = alu_valid_q;
    assign o_tx_start  = tx_start_q;
    assign o_busy      = busy_q;
    assign o_drop      = drop_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench: stimulus queues expected TX/timeout/drop events, a monitor pops and compares.
module tb_uart_frame_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned TT = 1600;

    typedef enum int {EvTx, EvTimeout, EvDrop} ev_kind_e;
    typedef struct {
        ev_kind_e      kind;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_baud_rate = 1'b0;
    logic          i_rx_done = 1'b0;
    logic [DW-1:0] i_rx_data = '0;
    logic [DW-1:0] i_alu_result;
    logic          i_tx_done = 1'b0;
    logic [DW-1:0] o_a, o_b, o_op, o_tx_data;
    logic          o_alu_valid, o_tx_start, o_busy, o_drop, o_timeout;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    uart_frame_ctrl #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_TICKS (TT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_baud_rate  (i_baud_rate),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_a          (o_a),
        .o_b          (o_b),
        .o_op         (o_op),
        .o_alu_valid  (o_alu_valid),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_drop       (o_drop),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    // External ALU: 0x20 add, 0x21 subtract, anything else xor.
    assign i_alu_result = (o_op == 8'h20) ? o_a + o_b :
                          (o_op == 8'h21) ? o_a - o_b : o_a ^ o_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_event(input ev_kind_e kind, input logic [DW-1:0] data,
                               input string name);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got unexpected event data %02h, required no event", name, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind != EvTimeout && e.data !== data)) begin
                n_fail++;
                $display("FAIL %s: got %s data %02h, required %s data %02h",
                         name, kind.name(), data, e.kind.name(), e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_tx_start) check_event(EvTx, o_tx_data, "tx_start");
            if (o_timeout)  check_event(EvTimeout, 8'h00, "timeout");
            if (o_drop)     check_event(EvDrop, o_tx_data, "drop");
        end
    end

    task automatic push_ev(input ev_kind_e kind, input logic [DW-1:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [DW-1:0] b, input logic tick);
        i_rx_done   = 1'b1;
        i_rx_data   = b;
        i_baud_rate = tick;
        cycle();
        i_rx_done   = 1'b0;
        i_baud_rate = 1'b0;
    endtask

    task automatic give_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            i_baud_rate = 1'b1;
            cycle();
            i_baud_rate = 1'b0;
            cycle();
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {o_a, o_b, o_op, o_tx_data, o_alu_valid, o_tx_start, o_busy, o_drop,
                     o_timeout}, 64'h0);
    endtask

    // Runs a frame up to WAIT_TX; op_ticks > 0 puts that many ticks before the opcode,
    // the last one coincident with the opcode byte.
    task automatic start_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] op, input logic [DW-1:0] exp,
                               input int op_ticks);
        push_ev(EvTx, exp);
        send_byte(a, 1'b0);
        send_byte(b, 1'b0);
        if (op_ticks > 0) give_ticks(op_ticks - 1);
        send_byte(op, op_ticks > 0);
        check("alu_valid_exec", o_alu_valid, 1);
        check("no_timeout_exec", o_timeout, 0);
        check("frame_regs", {o_a, o_b, o_op}, {a, b, op});
        cycle();
        check("tx_start_send", o_tx_start, 1);
        check("alu_valid_send", o_alu_valid, 0);
        cycle();
        check("tx_start_pulse", o_tx_start, 0);
        check("tx_data_held", o_tx_data, exp);
    endtask

    task automatic finish_tx(input int wait_cyc);
        repeat (wait_cyc) cycle();
        check("busy_wait_tx", o_busy, 1);
        i_tx_done = 1'b1;
        cycle();
        i_tx_done = 1'b0;
        check("busy_idle", o_busy, 0);
    endtask

    initial begin
        repeat (3) cycle();
        rst = 1'b0;
        check_all_zero("reset_outputs");

        start_frame(8'h05, 8'h03, 8'h20, 8'h08, 0);
        finish_tx(2);

        // Partial frame abandoned after the full tick budget.
        push_ev(EvTimeout, 8'h00);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        give_ticks(TT - 1);
        repeat (3) cycle();
        check("busy_before_expiry", o_busy, 1);
        give_ticks(1);
        check("busy_after_timeout", o_busy, 0);
        check("regs_kept", {o_a, o_b}, {8'h11, 8'h22});
        start_frame(8'hAA, 8'h55, 8'h20, 8'hFF, 0);
        finish_tx(1);

        // Opcode on the expiring tick wins.
        start_frame(8'h40, 8'h02, 8'h21, 8'h3E, TT);
        finish_tx(0);

        // Byte during WAIT_TX is dropped.
        start_frame(8'h10, 8'h20, 8'h20, 8'h30, 0);
        push_ev(EvDrop, 8'h30);
        send_byte(8'h77, 1'b0);
        check("drop_keeps_tx", o_tx_data, 8'h30);
        cycle();
        finish_tx(0);
        start_frame(8'h01, 8'h02, 8'h20, 8'h03, 0);
        finish_tx(0);

        // Reset while waiting for TX.
        start_frame(8'h0C, 8'h04, 8'h21, 8'h08, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_all_zero("reset_in_wait_tx");
        i_tx_done = 1'b1;
        cycle();
        i_tx_done = 1'b0;
        repeat (4) cycle();
        check("idle_after_reset", o_busy, 0);
        start_frame(8'h09, 8'h02, 8'h21, 8'h07, 0);
        finish_tx(0);

        // Reset with only operand A received.
        send_byte(8'h44, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_all_zero("reset_in_get_b");
        start_frame(8'h3C, 8'hFF, 8'h30, 8'hC3, 0);
        finish_tx(0);

        // Back-to-back frames, TX done one cycle after start.
        start_frame(8'h12, 8'h34, 8'h20, 8'h46, 0);
        finish_tx(0);
        start_frame(8'h50, 8'h0F, 8'h21, 8'h41, 0);
        finish_tx(0);

        repeat (4) cycle();
        check("events_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Consumes the byte stream produced by the UART receiver (o_rx_done/o_data) and assembles 3-byte command frames: operand A, operand B, opcode.
- Presents the frame to the external ALU and captures its result.
- Hands the result byte to the UART transmitter with a start/done handshake.
- Sits between RX and TX in the UART top level and shares the BaudRateGenerator tick, which drives its inter-byte timeout.

Parameters:
- DATA_WIDTH, 8, width of every UART byte, operand, opcode and result.
- TIMEOUT_TICKS, 1600, baud ticks allowed between bytes of one frame before the partial frame is discarded (about 10 byte times at 16x oversampling).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_baud_rate  in  1  one-cycle baud tick from BaudRateGenerator.
- i_rx_done  in  1  one-cycle pulse; i_rx_data is valid.
- i_rx_data  in  DATA_WIDTH  received byte.
- i_alu_result  in  DATA_WIDTH  combinational ALU result of o_a, o_b, o_op.
- i_tx_done  in  1  one-cycle pulse from TX at end of stop bit.
- o_a  out  DATA_WIDTH  registered operand A.
- o_b  out  DATA_WIDTH  registered operand B.
- o_op  out  DATA_WIDTH  registered opcode.
- o_alu_valid  out  1  high for the EXEC cycle.
- o_tx_start  out  1  one-cycle start pulse to TX.
- o_tx_data  out  DATA_WIDTH  byte for TX; held stable until i_tx_done.
- o_busy  out  1  high in any state other than GET_A.
- o_drop  out  1  one-cycle pulse: received byte discarded.
- o_timeout  out  1  one-cycle pulse: partial frame aborted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to GET_A.
  - All outputs and registers go to 0, including the timeout counter.
  - Reset mid-frame or mid-transmit discards everything; no tx_start is issued afterwards.
- States: GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- GET_A: on i_rx_done, o_a <= i_rx_data, clear timeout counter, go to GET_B.
- GET_B: on i_rx_done, o_b <= i_rx_data, clear counter, go to GET_OP.
- GET_OP: on i_rx_done, o_op <= i_rx_data, go to EXEC.
- Timeout counter (GET_B and GET_OP only):
  - Increments on each i_baud_rate and saturates.
  - When it reaches TIMEOUT_TICKS, go to GET_A, pulse o_timeout, clear counter.
  - i_rx_done in the same cycle as expiry: the byte wins and no timeout occurs.
  - Counter is held at 0 in all other states.
- EXEC:
  - Lasts exactly one cycle, with o_alu_valid=1.
  - o_tx_data <= i_alu_result at the end of the cycle; go to SEND.
- SEND:
  - Lasts one cycle, with o_tx_start=1; go to WAIT_TX.
- WAIT_TX:
  - Holds o_tx_data until i_tx_done, then goes to GET_A.
  - i_tx_done in any other state is ignored.
- Latency:
  - Opcode i_rx_done at cycle n gives EXEC at n+1 and o_tx_start at n+2.
- Dropped bytes:
  - i_rx_done during EXEC, SEND or WAIT_TX: byte discarded, o_drop pulses the next cycle, state unchanged.
- o_a, o_b and o_op keep their values until overwritten by the next frame.
- o_busy is a registered decode of the state.
- Widths: counter width is clog2(TIMEOUT_TICKS+1); no arithmetic is done on data bytes.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - DATA_WIDTH default;
  - TIMEOUT_TICKS default;
  - the counter-width function.
- One natural sub-module: baud_timeout. Inputs are clk, rst, clear, enable and tick; output is expired. It is reusable by RX for stuck-line detection.

Test Plan:
- Frame A=0x05, B=0x03, op=0x20, with i_alu_result driven as A+B -> o_alu_valid one cycle after the op byte, o_tx_start the next cycle with o_tx_data=0x08; after i_tx_done, o_busy=0.
- Send A=0x11 and B=0x22, then 1600 baud ticks with no byte -> o_timeout pulse, state GET_A. A following frame 0xAA, 0x55, op -> o_a=0xAA, o_b=0x55.
- i_rx_done coincident with the 1600th tick in GET_OP -> no o_timeout, EXEC follows.
- Byte 0x77 received during WAIT_TX -> o_drop pulse, o_tx_data unchanged, and the next frame's operand A is not 0x77.
- rst=1 asserted in WAIT_TX and in GET_B -> all outputs 0 the next cycle, no o_tx_start, and a full frame afterwards works.
- Two back-to-back frames with i_tx_done one cycle after o_tx_start -> two o_tx_start pulses carrying the correct distinct results.
